// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Brief    : Mode encodings and default moduli shared by the clock controller.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } clock_mode_t;

    localparam int c_SEC_MOD_DEFAULT  = 60;
    localparam int c_MIN_MOD_DEFAULT  = 60;
    localparam int c_HOUR_MOD_DEFAULT = 24;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/m_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : m_mod_counter
// Brief    : Modulo-N up counter with synchronous clear and same-edge carry.
// Revision : 1.0 - initial release
// ============================================================================
module m_mod_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             res,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_modulus,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_top;

    // ">=" keeps the count in range even if a value above the top ever appears
    assign w_at_top = (r_count >= (i_modulus - WIDTH'(1)));
    assign o_carry  = i_en & w_at_top;
    assign o_count  = r_count;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_top ? '0 : (r_count + WIDTH'(1));
        end
    end

endmodule : m_mod_counter
`default_nettype wire

// File: rtl/m_clock_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : m_clock_adjust_ctrl
// Brief    : HH:MM:SS clock with RUN/SET_H/SET_M/SET_S adjust FSM and blink.
// Revision : 1.0 - initial release
// ============================================================================
module m_clock_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MOD  = c_SEC_MOD_DEFAULT,
    parameter int MIN_MOD  = c_MIN_MOD_DEFAULT,
    parameter int HOUR_MOD = c_HOUR_MOD_DEFAULT
) (
    input  logic       clk,
    input  logic       res,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_pulse
);

    clock_mode_t r_state;
    clock_mode_t w_state_next;
    logic        r_blink;
    logic        w_blink_next;
    logic        r_day_pulse;
    logic        w_run;
    logic        w_up_eff;
    logic        w_sec_en;
    logic        w_sec_clr;
    logic        w_min_en;
    logic        w_hour_en;
    logic        w_sec_carry;
    logic        w_min_carry;
    logic        w_hour_carry;

    // btn_mode wins over btn_up; carries only cascade while running
    assign w_run     = (r_state == RUN);
    assign w_up_eff  = btn_up & ~btn_mode;
    assign w_sec_en  = w_run & tick;
    assign w_sec_clr = (r_state == SET_S) & w_up_eff;
    assign w_min_en  = (w_run & w_sec_carry) | ((r_state == SET_M) & w_up_eff);
    assign w_hour_en = (w_run & w_min_carry) | ((r_state == SET_H) & w_up_eff);

    m_mod_counter #(.WIDTH(6)) u_sec (
        .clk       (clk),
        .res       (res),
        .i_en      (w_sec_en),
        .i_clr     (w_sec_clr),
        .i_modulus (6'(SEC_MOD)),
        .o_count   (sec),
        .o_carry   (w_sec_carry)
    );

    m_mod_counter #(.WIDTH(6)) u_min (
        .clk       (clk),
        .res       (res),
        .i_en      (w_min_en),
        .i_clr     (1'b0),
        .i_modulus (6'(MIN_MOD)),
        .o_count   (min),
        .o_carry   (w_min_carry)
    );

    m_mod_counter #(.WIDTH(5)) u_hour (
        .clk       (clk),
        .res       (res),
        .i_en      (w_hour_en),
        .i_clr     (1'b0),
        .i_modulus (5'(HOUR_MOD)),
        .o_count   (hour),
        .o_carry   (w_hour_carry)
    );

    always_comb begin
        w_state_next = r_state;
        w_blink_next = r_blink;
        if (btn_mode) begin
            w_blink_next = 1'b0;
            case (r_state)
                RUN:     w_state_next = SET_H;
                SET_H:   w_state_next = SET_M;
                SET_M:   w_state_next = SET_S;
                SET_S:   w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end else if (w_run) begin
            w_blink_next = 1'b0;
        end else if (tick) begin
            w_blink_next = ~r_blink;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= RUN;
            r_blink     <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_blink     <= w_blink_next;
            r_day_pulse <= w_run & w_hour_carry;
        end
    end

    assign mode      = r_state;
    assign blink     = r_blink;
    assign day_pulse = r_day_pulse;

endmodule : m_clock_adjust_ctrl
`default_nettype wire
